// File: rtl/step_sequencer_controller.sv
// step_sequencer_controller: 16-step pattern sequencer with playhead, note pulses and gate output (GATE_STRETCH_EN stretches gate)
module step_sequencer_controller #(
  parameter int STEP_CYCLES = 1_500_000,
  parameter int GATE_CYCLES = 120_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_pressed,
  input  logic [3:0]  btn_index,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] pattern,
  output logic [3:0]  step_index,
  output logic        running,
  output logic        step_tick,
  output logic        note_on,
  output logic        gate
);
  typedef enum logic {STOPPED, RUNNING} state_t;
  localparam logic [23:0] STEP_LAST = 24'(STEP_CYCLES - 1);
  state_t      state;
  logic [23:0] step_cnt;
  logic [3:0]  nxt_idx;
  logic        term;
  logic        tick_next;
  logic        note_next;
  // next-step decode; note lookup uses the pattern before any same-cycle toggle
  always_comb begin
    nxt_idx   = step_index + 4'd1;
    term      = state == RUNNING && step_cnt == STEP_LAST;
    tick_next = !stop && (start || term);
    note_next = !stop && (start ? pattern[0] : term && pattern[nxt_idx]);
  end
  // playback FSM, step counter, pattern edits and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STOPPED;
      running    <= 1'b0;
      pattern    <= '0;
      step_index <= '0;
      step_cnt   <= '0;
      step_tick  <= 1'b0;
      note_on    <= 1'b0;
    end else begin
      pattern   <= clear ? '0 : btn_pressed ? pattern ^ (16'd1 << btn_index) : pattern;
      step_tick <= tick_next;
      note_on   <= note_next;
      if (stop) begin
        state    <= STOPPED;
        running  <= 1'b0;
        step_cnt <= '0;
      end else if (start) begin
        state      <= RUNNING;
        running    <= 1'b1;
        step_index <= '0;
        step_cnt   <= '0;
      end else if (state == RUNNING) begin
        step_cnt   <= term ? '0 : step_cnt + 24'd1;
        step_index <= term ? nxt_idx : step_index;
      end
    end
  end
`ifdef GATE_STRETCH_EN
  localparam logic [23:0] GATE_LOAD = 24'(GATE_CYCLES - 1);
  logic [23:0] gate_cnt;
  // gate holds for GATE_CYCLES cycles from each note, retriggered by a new note
  always_ff @(posedge clk) begin
    if (rst) begin
      gate     <= 1'b0;
      gate_cnt <= '0;
    end else if (note_next) begin
      gate     <= 1'b1;
      gate_cnt <= GATE_LOAD;
    end else if (gate_cnt != '0) begin
      gate_cnt <= gate_cnt - 24'd1;
    end else begin
      gate <= 1'b0;
    end
  end
`else
  // gate mirrors note_on; GATE_CYCLES is legal only when nonzero so this term is always true
  always_ff @(posedge clk) begin
    gate <= rst ? 1'b0 : note_next && GATE_CYCLES > 0;
  end
`endif
endmodule
